// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one memory access per load/store, stalling the pipeline until mem_ack.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses complete at once with MisalignM instead of accessing memory.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        DoneM,
  output logic        MisalignM,
  output logic [1:0]  state_o
);
  // Handshake: mem_req stays high with every request field frozen until the cycle
  // mem_ack is sampled high; that same edge ends the access and delivers mem_rdata.

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;

  logic        access;
  logic        is_byte, is_half;
  logic [1:0]  lane;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic        start_mem;

  assign access = MemReadM | MemWriteM;

  // Unlisted Funct3M encodings fall through to a word access.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    case (Funct3M)
      3'b000, 3'b100: is_byte = 1'b1;
      3'b001, 3'b101: is_half = 1'b1;
      default: ;
    endcase
  end

  // Lane offset masked to the natural alignment of the access size.
  always_comb begin
    if (is_byte) begin
      lane       = ALUResultM[1:0];
      be_next    = 4'b0001 << lane;
      wdata_next = {4{WriteDataM[7:0]}};
    end else if (is_half) begin
      lane       = {ALUResultM[1], 1'b0};
      be_next    = 4'b0011 << lane;
      wdata_next = {2{WriteDataM[15:0]}};
    end else begin
      lane       = 2'b00;
      be_next    = 4'b1111;
      wdata_next = WriteDataM;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic mis_q;
  assign misaligned = (is_half & ALUResultM[0]) | (~is_byte & ~is_half & (|ALUResultM[1:0]));
  assign start_mem  = access & ~misaligned;
  assign MisalignM  = (state_q == DONE) & mis_q;
`else
  assign start_mem  = access;
  assign MisalignM  = 1'b0;
`endif

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    StallM  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          StallM  = 1'b1;
          state_d = start_mem ? BUSY : DONE;
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (mem_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) StallM = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_mem) begin
        we_q    <= MemWriteM;
        addr_q  <= {ALUResultM[31:2], 2'b00};
        be_q    <= be_next;
        wdata_q <= wdata_next;
        f3_q    <= Funct3M;
        lane_q  <= lane;
      end
      if (state_q == BUSY && mem_ack && !we_q) rdata_q <= load_val;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         mis_q <= 1'b0;
    else if (state_q == IDLE && access) mis_q <= misaligned;
  end
`endif

  assign mem_req   = (state_q == BUSY);
  assign DoneM     = (state_q == DONE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign ReadDataM = rdata_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts every cycle's outputs.
module tb_load_store_unit;
  logic        clk, rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, ReadDataM;
  logic [3:0]  mem_be;
  logic        StallM, DoneM, MisalignM;
  logic [1:0]  state_o;

  load_store_unit dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ReadDataM(ReadDataM), .StallM(StallM), .DoneM(DoneM), .MisalignM(MisalignM),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // model state
  logic [31:0] model_rd = 32'd0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_done = 1'b0, exp_mis = 1'b0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_addr = 32'd0, cur_wdata = 32'd0;
  logic [3:0]  cur_be = 4'd0;
  logic [31:0] exp_q[$];
  bit          checking = 1'b0;

  // observations
  int          stall_cnt = 0, req_eps = 0, done_cnt = 0, mis_cnt = 0, cyc = 0;
  int          done_t[$];
  logic        prev_req = 1'b0;
  logic        seen_we = 1'b0;
  logic [31:0] seen_addr = 32'd0, seen_wdata = 32'd0;
  logic [3:0]  seen_be = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_size(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int model_lane(input logic [2:0] f3, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    return off - (off % model_size(f3));
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = model_size(f3);
    return 4'(((1 << sz) - 1) << model_lane(f3, addr));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = model_size(f3);
    if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    int sz;
    bit sgn;
    sz  = model_size(f3);
    sgn = (f3 == 3'b000 || f3 == 3'b001);
    v   = rdata >> (8 * model_lane(f3, addr));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = model_size(f3);
    return (addr % sz) != 0;
  endfunction

  // compare process: every cycle after the first reset
  always @(negedge clk) begin
    if (checking) begin
      chk("StallM", {31'd0, StallM}, {31'd0, exp_stall});
      chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      chk("DoneM", {31'd0, DoneM}, {31'd0, exp_done});
      chk("MisalignM", {31'd0, MisalignM}, {31'd0, exp_mis});
      chk("ReadDataM", ReadDataM, model_rd);
      if (mem_req) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, cur_we});
        chk("mem_addr", mem_addr, cur_addr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, cur_be});
        chk("mem_wdata", mem_wdata, cur_wdata);
        seen_we = mem_we; seen_addr = mem_addr; seen_be = mem_be; seen_wdata = mem_wdata;
      end
      if (DoneM) begin
        done_cnt++;
        done_t.push_back(cyc);
        if (exp_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else chk("done_rdata", ReadDataM, exp_q.pop_front());
      end
      if (StallM) stall_cnt++;
      if (MisalignM) mis_cnt++;
      if (mem_req && !prev_req) req_eps++;
      prev_req = mem_req;
    end
    cyc++;
  end

  // driver: one access starting in IDLE, k = BUSY cycle on which mem_ack arrives
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int k, input bit tied);
    bit trap;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = model_mis(f3, addr);
`endif
    cur_we = wr; cur_addr = {addr[31:2], 2'b00};
    cur_be = model_be(f3, addr); cur_wdata = model_wdata(f3, wd);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr;
    WriteDataM = wd; mem_rdata = rdata;
    exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
    @(posedge clk); #1;
    if (trap) begin
      exp_stall = 1'b0; exp_done = 1'b1; exp_mis = 1'b1;
      exp_q.push_back(model_rd);
    end else begin
      exp_req = 1'b1;
      for (int n = 1; n <= k; n++) begin
        mem_ack = tied || (n == k);
        @(posedge clk); #1;
      end
      if (!tied) mem_ack = 1'b0;
      if (!wr) model_rd = model_load(f3, addr, rdata);
      exp_q.push_back(model_rd);
      exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b1;
    end
    @(posedge clk); #1;
    exp_done = 1'b0; exp_mis = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  initial begin
    int d0, r0, m0;
    rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0;
    ALUResultM = 32'd0; WriteDataM = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ReadDataM", ReadDataM, 32'd0);
    chk("rst_StallM", {31'd0, StallM}, 32'd0);
    chk("rst_DoneM", {31'd0, DoneM}, 32'd0);
    chk("rst_MisalignM", {31'd0, MisalignM}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checking = 1'b1;

    // lw 0x100, ack on 2nd BUSY cycle
    stall_cnt = 0; d0 = done_cnt;
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 2, 1'b0);
    chk("lw_stall_cycles", stall_cnt, 32'd3);
    chk("lw_done_pulses", done_cnt - d0, 32'd1);
    chk("lw_be", {28'd0, seen_be}, 32'hF);
    chk("lw_data", ReadDataM, 32'hDEADBEEF);

    // sub-word loads from one read word
    access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF0000, 1, 1'b0);
    chk("lb_data", ReadDataM, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF0000, 3, 1'b0);
    chk("lbu_data", ReadDataM, 32'h00000080);
    access(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF0000, 1, 1'b0);
    chk("lhu_data", ReadDataM, 32'h000080FF);
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'h80FF0000, 2, 1'b0);
    chk("lh_data", ReadDataM, 32'hFFFF80FF);

    // stores
    access(1'b0, 1'b1, 3'b001, 32'h0A2, 32'h1234ABCD, 32'd0, 1, 1'b0);
    chk("sh_addr", seen_addr, 32'h0A0);
    chk("sh_be", {28'd0, seen_be}, 32'hC);
    chk("sh_wdata", seen_wdata, 32'hABCDABCD);
    chk("sh_we", {31'd0, seen_we}, 32'd1);
    access(1'b0, 1'b1, 3'b000, 32'h0A1, 32'h00000055, 32'd0, 2, 1'b0);
    chk("sb_be", {28'd0, seen_be}, 32'h2);
    chk("sb_wdata", seen_wdata, 32'h55555555);
    chk("st_keeps_rdata", ReadDataM, 32'hFFFF80FF);

    // unlisted funct3 behaves as a word load
    access(1'b1, 1'b0, 3'b111, 32'h104, 32'd0, 32'h01234567, 1, 1'b0);
    chk("f3_111_be", {28'd0, seen_be}, 32'hF);
    chk("f3_111_data", ReadDataM, 32'h01234567);

    // read and write together: store wins, ReadDataM untouched
    access(1'b1, 1'b1, 3'b010, 32'h0A4, 32'hCAFEF00D, 32'h99999999, 1, 1'b0);
    chk("both_we", {31'd0, seen_we}, 32'd1);
    chk("both_wdata", seen_wdata, 32'hCAFEF00D);
    chk("both_rdata", ReadDataM, 32'h01234567);

    // misaligned word load
    r0 = req_eps; m0 = mis_cnt;
    access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'h11223344, 1, 1'b0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_no_req", req_eps - r0, 32'd0);
    chk("mis_pulse", mis_cnt - m0, 32'd1);
    chk("mis_rdata", ReadDataM, 32'h01234567);
`else
    chk("mis_req", req_eps - r0, 32'd1);
    chk("mis_pulse", mis_cnt - m0, 32'd0);
    chk("mis_addr", seen_addr, 32'h100);
    chk("mis_be", {28'd0, seen_be}, 32'hF);
    chk("mis_rdata", ReadDataM, 32'h11223344);
`endif

    // reset in the middle of BUSY
    d0 = done_cnt;
    cur_we = 1'b0; cur_addr = 32'h200; cur_be = 4'hF; cur_wdata = 32'd0;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h200;
    exp_stall = 1'b1; exp_req = 1'b0;
    @(posedge clk); #1;
    exp_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_stall = 1'b0; exp_req = 1'b0; model_rd = 32'd0;
    #1;
    chk("rstbusy_req", {31'd0, mem_req}, 32'd0);
    chk("rstbusy_rdata", ReadDataM, 32'd0);
    chk("rstbusy_state", {30'd0, state_o}, 32'd0);
    chk("rstbusy_stall", {31'd0, StallM}, 32'd0);
    MemReadM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    repeat (3) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    chk("rstbusy_no_done", done_cnt - d0, 32'd0);
    chk("rstbusy_late_ack", ReadDataM, 32'd0);

    // mem_ack tied high, back-to-back loads
    r0 = req_eps; d0 = done_t.size();
    mem_ack = 1'b1;
    access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'hA5A5A5A5, 1, 1'b1);
    access(1'b1, 1'b0, 3'b000, 32'h301, 32'd0, 32'h0000F000, 1, 1'b1);
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_req_episodes", req_eps - r0, 32'd2);
    chk("b2b_done_count", done_t.size() - d0, 32'd2);
    if (done_t.size() - d0 == 2)
      chk("b2b_done_spacing", done_t[d0 + 1] - done_t[d0], 32'd3);
    chk("b2b_rdata", ReadDataM, 32'hFFFFFFF0);
    chk("exp_q_drained", exp_q.size(), 32'd0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
